// File: rtl/hazard_ctl_if.sv
// hazard_ctl_if: bundle of hazard-detection inputs and pipeline control
// outputs exchanged between the pipeline datapath and hazard_ctl.
//   master : datapath side (drives register ids / enables, consumes controls)
//   slave  : hazard_ctl side
// HAZARD_PERF_CNT_EN adds StallCycles_o, FlushCount_o and LoadUseCount_o.
interface hazard_ctl_if;
  logic [4:0]  Rs1D_i, Rs2D_i;
  logic [4:0]  Rs1E_i, Rs2E_i;
  logic [4:0]  RdE_i;
  logic [1:0]  ResultSrcE_i;
  logic [4:0]  RdM_i;
  logic        RegWriteM_i;
  logic [4:0]  RdW_i;
  logic        RegWriteW_i;
  logic        PCSrcE_i;
  logic        MissM_i;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        StallF_o, StallD_o, StallE_o, StallM_o;
  logic        FlushD_o, FlushE_o, FlushW_o;
  logic        ErrTimeout_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles_o, FlushCount_o, LoadUseCount_o;
`endif

  modport master (
    output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i,
    output RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, PCSrcE_i, MissM_i,
    input  ForwardAE_o, ForwardBE_o,
    input  StallF_o, StallD_o, StallE_o, StallM_o,
    input  FlushD_o, FlushE_o, FlushW_o,
    input  ErrTimeout_o
`ifdef HAZARD_PERF_CNT_EN
    , input StallCycles_o, FlushCount_o, LoadUseCount_o
`endif
  );

  modport slave (
    input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i,
    input  RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, PCSrcE_i, MissM_i,
    output ForwardAE_o, ForwardBE_o,
    output StallF_o, StallD_o, StallE_o, StallM_o,
    output FlushD_o, FlushE_o, FlushW_o,
    output ErrTimeout_o
`ifdef HAZARD_PERF_CNT_EN
    , output StallCycles_o, FlushCount_o, LoadUseCount_o
`endif
  );
endinterface

// File: rtl/hazard_ctl.sv
// hazard_ctl: central hazard controller for the five-stage RV32I pipeline.
// Ports:
//   clk  - pipeline clock
//   rst  - synchronous active-high reset
//   hz   - hazard_ctl_if.slave: register ids/enables in, forward/stall/flush
//          controls (combinational) and sticky ErrTimeout_o (registered) out
// Parameter MISS_TIMEOUT (2..65535): consecutive miss cycles before timeout.
// Macro HAZARD_PERF_CNT_EN: adds saturating 32-bit stall/flush/load-use
// counters on the interface.
module hazard_ctl #(
  parameter int unsigned MISS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctl_if.slave hz
);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MISS_TIMEOUT);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;
  logic             lw_stall;
  logic             branch_flush;
  logic             lw_apply;

  // Operand forwarding: Memory result beats Writeback result.
  always_comb begin
    hz.ForwardAE_o = 2'b00;
    hz.ForwardBE_o = 2'b00;
    if (hz.RegWriteM_i && (hz.RdM_i != 5'd0) && (hz.RdM_i == hz.Rs1E_i))
      hz.ForwardAE_o = 2'b10;
    else if (hz.RegWriteW_i && (hz.RdW_i != 5'd0) && (hz.RdW_i == hz.Rs1E_i))
      hz.ForwardAE_o = 2'b01;
    if (hz.RegWriteM_i && (hz.RdM_i != 5'd0) && (hz.RdM_i == hz.Rs2E_i))
      hz.ForwardBE_o = 2'b10;
    else if (hz.RegWriteW_i && (hz.RdW_i != 5'd0) && (hz.RdW_i == hz.Rs2E_i))
      hz.ForwardBE_o = 2'b01;
  end

  assign lw_stall = (hz.ResultSrcE_i == 2'b01) && (hz.RdE_i != 5'd0) &&
                    ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));

  // A pending miss freezes the whole pipe, so a taken branch waits for it.
  assign branch_flush = !hz.MissM_i && hz.PCSrcE_i;
  assign lw_apply     = !hz.MissM_i && !hz.PCSrcE_i && lw_stall;

  // Stall/flush priority: miss > branch > load-use.
  always_comb begin
    hz.StallF_o = 1'b0;
    hz.StallD_o = 1'b0;
    hz.StallE_o = 1'b0;
    hz.StallM_o = 1'b0;
    hz.FlushD_o = 1'b0;
    hz.FlushE_o = 1'b0;
    hz.FlushW_o = 1'b0;
    if (hz.MissM_i) begin
      hz.StallF_o = 1'b1;
      hz.StallD_o = 1'b1;
      hz.StallE_o = 1'b1;
      hz.StallM_o = 1'b1;
      hz.FlushW_o = 1'b1;
    end else if (branch_flush) begin
      hz.FlushD_o = 1'b1;
      hz.FlushE_o = 1'b1;
    end else if (lw_apply) begin
      hz.StallF_o = 1'b1;
      hz.StallD_o = 1'b1;
      hz.FlushE_o = 1'b1;
    end
  end

  // Miss-tracking FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      miss_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state: count consecutive miss cycles while in MISS, sticky error.
  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (hz.MissM_i) state_d = ST_MISS;
      end
      ST_MISS: begin
        if (hz.MissM_i) begin
          if (miss_cnt_q != TIMEOUT_VAL) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end else begin
          state_d    = ST_RUN;
          miss_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        miss_cnt_d = '0;
      end
    endcase
    if (miss_cnt_d == TIMEOUT_VAL) err_d = 1'b1;
  end

  assign hz.ErrTimeout_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PERF_W = 32;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] stall_cycles_q, flush_count_q, load_use_count_q;
  logic              any_stall;

  assign any_stall = hz.MissM_i || lw_apply;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q   <= '0;
      flush_count_q    <= '0;
      load_use_count_q <= '0;
    end else begin
      if (any_stall && (stall_cycles_q != PERF_MAX))
        stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      if (branch_flush && (flush_count_q != PERF_MAX))
        flush_count_q <= flush_count_q + PERF_W'(1);
      if (lw_apply && (load_use_count_q != PERF_MAX))
        load_use_count_q <= load_use_count_q + PERF_W'(1);
    end
  end

  assign hz.StallCycles_o  = stall_cycles_q;
  assign hz.FlushCount_o   = flush_count_q;
  assign hz.LoadUseCount_o = load_use_count_q;
`endif
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed + short random stimulus; expected controls come
// from a reference model, queued at drive time and compared on the falling
// clock edge.
module tb_hazard_ctl;
  localparam int unsigned T = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic [4:0] rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
    logic       pcsrc;
    logic       miss;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic [3:0] stall;   // {F,D,E,M}
    logic [2:0] flush;   // {D,E,W}
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int   m_run = 0;
  logic m_err = 1'b0;
  int unsigned m_stall_cyc = 0, m_flush_cnt = 0, m_lu_cnt = 0;

  hazard_ctl_if hz ();

  hazard_ctl #(.MISS_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_comb(input stim_t s);
    exp_t e;
    logic lw;
    e = '0;
    if (s.rwm && s.rdm != 5'd0 && s.rdm == s.rs1e)      e.fa = 2'b10;
    else if (s.rww && s.rdw != 5'd0 && s.rdw == s.rs1e) e.fa = 2'b01;
    if (s.rwm && s.rdm != 5'd0 && s.rdm == s.rs2e)      e.fb = 2'b10;
    else if (s.rww && s.rdw != 5'd0 && s.rdw == s.rs2e) e.fb = 2'b01;
    lw = (s.rsrc == 2'b01) && (s.rde != 5'd0) && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (s.miss) begin
      e.stall = 4'b1111;
      e.flush = 3'b001;
    end else if (s.pcsrc) begin
      e.flush = 3'b110;
    end else if (lw) begin
      e.stall = 4'b1100;
      e.flush = 3'b010;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    rst             = s.rst;
    hz.Rs1D_i       = s.rs1d;
    hz.Rs2D_i       = s.rs2d;
    hz.Rs1E_i       = s.rs1e;
    hz.Rs2E_i       = s.rs2e;
    hz.RdE_i        = s.rde;
    hz.ResultSrcE_i = s.rsrc;
    hz.RdM_i        = s.rdm;
    hz.RegWriteM_i  = s.rwm;
    hz.RdW_i        = s.rdw;
    hz.RegWriteW_i  = s.rww;
    hz.PCSrcE_i     = s.pcsrc;
    hz.MissM_i      = s.miss;
  endtask

  // One cycle: drive, queue expectation, compare mid-cycle, advance model.
  task automatic step(input stim_t s);
    exp_t e;
    exp_t got;
    apply(s);
    e     = model_comb(s);
    e.err = m_err;
    sb.push_back(e);
    @(negedge clk);
    got = '0;
    got.fa    = hz.ForwardAE_o;
    got.fb    = hz.ForwardBE_o;
    got.stall = {hz.StallF_o, hz.StallD_o, hz.StallE_o, hz.StallM_o};
    got.flush = {hz.FlushD_o, hz.FlushE_o, hz.FlushW_o};
    got.err   = hz.ErrTimeout_o;
    e = sb.pop_front();
    check("fwd_a", 32'(got.fa), 32'(e.fa));
    check("fwd_b", 32'(got.fb), 32'(e.fb));
    check("stall", 32'(got.stall), 32'(e.stall));
    check("flush", 32'(got.flush), 32'(e.flush));
    check("err_timeout", 32'(got.err), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles", hz.StallCycles_o, m_stall_cyc);
    check("flush_count", hz.FlushCount_o, m_flush_cnt);
    check("load_use_count", hz.LoadUseCount_o, m_lu_cnt);
`endif
    @(posedge clk);
    if (s.rst) begin
      m_run = 0;
      m_err = 1'b0;
      m_stall_cyc = 0;
      m_flush_cnt = 0;
      m_lu_cnt = 0;
    end else begin
      m_run = s.miss ? m_run + 1 : 0;
      if (m_run >= int'(T) + 1) m_err = 1'b1;
      if (e.stall != 4'b0000) m_stall_cyc++;
      if (e.flush == 3'b110)  m_flush_cnt++;
      if (e.stall == 4'b1100) m_lu_cnt++;
    end
    #1;
  endtask

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    apply(s);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    s = '0;
    step(s);

    // Forwarding: Memory beats Writeback, then Writeback, then x0 ignored
    s = '0; s.rwm = 1'b1; s.rdm = 5'd5; s.rww = 1'b1; s.rdw = 5'd5; s.rs1e = 5'd5;
    step(s);
    s.rwm = 1'b0;
    step(s);
    s.rwm = 1'b1; s.rdm = 5'd0; s.rdw = 5'd0; s.rs1e = 5'd0;
    step(s);
    s = '0; s.rww = 1'b1; s.rdw = 5'd9; s.rs2e = 5'd9;
    step(s);
    s.rwm = 1'b1; s.rdm = 5'd9;
    step(s);

    // Load-use on Rs2D, then bubble in E
    s = '0; s.rsrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    step(s);
    s.rde = 5'd0;
    step(s);
    s = '0; s.rsrc = 2'b01; s.rde = 5'd3; s.rs1d = 5'd3;
    step(s);
    s = '0; s.rsrc = 2'b01; s.rde = 5'd0; s.rs1d = 5'd0;
    step(s);
    s = '0; s.rsrc = 2'b00; s.rde = 5'd3; s.rs1d = 5'd3;
    step(s);

    // Branch over load-use
    s = '0; s.rsrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7; s.pcsrc = 1'b1;
    step(s);

    // Miss with deferred branch
    s.miss = 1'b1;
    repeat (3) step(s);
    s.miss = 1'b0;
    step(s);
    s = '0;
    step(s);

    // Timeout, stickiness after miss ends, clear by reset
    s = '0; s.miss = 1'b1;
    repeat (6) step(s);
    s.miss = 1'b0;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    step(s);

    // Reset mid-miss restarts the timeout window
    s = '0; s.miss = 1'b1;
    repeat (3) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    repeat (6) step(s);
    s.miss = 1'b0;
    step(s);
    s.rst = 1'b1;
    step(s);

    // Short random mix
    for (int i = 0; i < 60; i++) begin
      s = '0;
      s.rs1d  = 5'($urandom_range(0, 3));
      s.rs2d  = 5'($urandom_range(0, 3));
      s.rs1e  = 5'($urandom_range(0, 3));
      s.rs2e  = 5'($urandom_range(0, 3));
      s.rde   = 5'($urandom_range(0, 3));
      s.rsrc  = 2'($urandom_range(0, 3));
      s.rdm   = 5'($urandom_range(0, 3));
      s.rwm   = 1'($urandom_range(0, 1));
      s.rdw   = 5'($urandom_range(0, 3));
      s.rww   = 1'($urandom_range(0, 1));
      s.pcsrc = ($urandom_range(0, 3) == 0);
      s.miss  = ($urandom_range(0, 2) == 0);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Central hazard controller for the five-stage RV32I pipeline. Drives the stall, flush and forwarding controls consumed by the F/D, D/E, E/M and M/W pipeline registers. Covers three cases:
- load-use stalls in Decode;
- control-hazard flushes from branches and jumps resolved in Execute;
- multi-cycle data-memory miss stalls in Memory.

A small FSM tracks outstanding misses and raises a sticky timeout error. Optional performance counters are compiled in by a macro.

## Interface
Parameters:
- MISS_TIMEOUT, 64, consecutive miss cycles after which ErrTimeout_o sets; legal range 2..65535.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Rs1D_i, Rs2D_i  in  5  source registers of the instruction in Decode
- Rs1E_i, Rs2E_i  in  5  source registers of the instruction in Execute
- RdE_i  in  5  destination register in Execute
- ResultSrcE_i  in  2  Execute result select; 2'b01 = load
- RdM_i  in  5  destination register in Memory
- RegWriteM_i  in  1  Memory-stage register write enable
- RdW_i  in  5  destination register in Writeback
- RegWriteW_i  in  1  Writeback-stage register write enable
- PCSrcE_i  in  1  taken branch or jump resolved in Execute
- MissM_i  in  1  data memory not ready this cycle
- ForwardAE_o, ForwardBE_o  out  2  operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result
- StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold the corresponding pipeline register
- FlushD_o, FlushE_o, FlushW_o  out  1  load a bubble into the corresponding pipeline register
- ErrTimeout_o  out  1  sticky miss-timeout flag

## Operation
Forwarding (combinational, all states):
- ForwardAE_o = 10 if RegWriteM_i, RdM_i != 0 and RdM_i == Rs1E_i.
- Otherwise ForwardAE_o = 01 if RegWriteW_i, RdW_i != 0 and RdW_i == Rs1E_i.
- Otherwise ForwardAE_o = 00.
- ForwardBE_o follows the same rules using Rs2E_i.
- Memory always beats Writeback.

Load-use hazard:
- lwStall = (ResultSrcE_i == 01) and RdE_i != 0 and (RdE_i == Rs1D_i or RdE_i == Rs2D_i).

Priority, highest first:
- MissM_i = 1: StallF_o, StallD_o, StallE_o and StallM_o = 1; FlushW_o = 1. Load-use and branch controls are forced to 0.
- PCSrcE_i = 1: FlushD_o and FlushE_o = 1; StallF_o and StallD_o = 0, even if lwStall is true.
- lwStall: StallF_o, StallD_o and FlushE_o = 1.
- Otherwise all stall and flush outputs are 0.

FSM, registered state:
- RUN → MISS when MissM_i = 1 at a rising edge.
- MISS stays in MISS while MissM_i = 1.
- MISS → RUN at the first edge with MissM_i = 0.
- Stall and flush outputs depend only on the current inputs. The FSM governs only the timeout counter.

Miss counter (16 bits):
- Clears on entry to RUN.
- In MISS, increments by 1 per cycle and saturates at MISS_TIMEOUT.
- When the count reaches MISS_TIMEOUT, ErrTimeout_o sets. It stays set until rst, including after the FSM returns to RUN.

Reset values:
- State = RUN, miss counter = 0, ErrTimeout_o = 0.
- All perf counters = 0.
- Combinational outputs follow their inputs during reset.

## Timing
- Forward, stall and flush outputs are combinational; zero-cycle latency from inputs.
- A load-use stall lasts exactly 1 cycle: after the bubble enters E, lwStall clears naturally.
- Miss entry with MissM_i first high in cycle N:
  - stalls asserted in cycle N;
  - state = MISS from cycle N+1;
  - counter = 1 after the edge ending cycle N+1.
- Miss exit with MissM_i low in cycle K: stalls drop in cycle K; state = RUN from K+1.
- Timeout: with MissM_i held high continuously from cycle N, ErrTimeout_o rises after the edge ending cycle N+MISS_TIMEOUT.
- rst asserted mid-miss: state = RUN and counter = 0 at the next edge. ErrTimeout_o clears. Stall outputs still follow MissM_i.
- A branch taken during a miss is deferred by the priority order. E and M are held, so PCSrcE_i remains asserted and the flush applies in the first cycle after MissM_i falls.

## Configuration
- HAZARD_PERF_CNT_EN defined adds three outputs, all 32 bits, saturating at 32'hFFFF_FFFF and reset to 0:
  - StallCycles_o: cycles with any stall output high;
  - FlushCount_o: cycles with FlushE_o high due to PCSrcE_i;
  - LoadUseCount_o: cycles in which the load-use stall applies.
- HAZARD_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Forwarding: RegWriteM_i=1, RdM_i=5, RegWriteW_i=1, RdW_i=5, Rs1E_i=5 -> ForwardAE_o=10. Drop RegWriteM_i -> ForwardAE_o=01. RdM_i=RdW_i=0 with Rs1E_i=0 -> ForwardAE_o=00.
- Load-use: ResultSrcE_i=01, RdE_i=7, Rs2D_i=7 -> StallF_o=StallD_o=FlushE_o=1 for one cycle. Next cycle with bubble in E (RdE_i=0) -> all 0.
- Branch over load-use: PCSrcE_i=1 and lwStall both true -> FlushD_o=FlushE_o=1, StallF_o=StallD_o=0.
- Miss with deferred branch: MissM_i high for 3 cycles with PCSrcE_i=1 -> 4 stalls high, FlushW_o=1, FlushD_o=FlushE_o=0 for 3 cycles. Cycle 4 -> FlushD_o=FlushE_o=1. ErrTimeout_o=0.
- Timeout: MISS_TIMEOUT=4, MissM_i high for 6 cycles -> ErrTimeout_o rises after the 5th edge and stays 1 after MissM_i falls. rst for one cycle -> ErrTimeout_o=0 and state=RUN.
- Perf counters (HAZARD_PERF_CNT_EN defined): after the above sequences, StallCycles_o, FlushCount_o and LoadUseCount_o match the per-cycle counts. Preload a counter near saturation -> it holds at 32'hFFFF_FFFF.
